// File: rtl/sgdmac_desc_ctrl.sv
// Scatter-gather DMA descriptor walker: fetches 4-word descriptors one read at a time,
// issues one copy command per non-empty descriptor and follows NEXT pointers until the chain ends.
module sgdmac_desc_ctrl #(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [31:0]      start_addr_i,
    output logic             done_o,
    output logic             busy_o,
    output logic             err_o,
    output logic             rd_req_o,
    output logic [31:0]      rd_addr_o,
    input  logic             rd_gnt_i,
    input  logic             rd_valid_i,
    input  logic [31:0]      rd_data_i,
    output logic             cmd_valid_o,
    input  logic             cmd_ready_i,
    output logic [31:0]      cmd_src_o,
    output logic [31:0]      cmd_dst_o,
    output logic [LEN_W-1:0] cmd_len_o,
    input  logic             xfer_done_i,
    output logic [CNT_W-1:0] desc_cnt_o
);

    localparam int unsigned AW = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_REQ    = 3'd1,
        RD_DATA   = 3'd2,
        ISSUE     = 3'd3,
        WAIT_XFER = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [AW-1:0]    ptr_q, ptr_d;
    logic [1:0]       idx_q, idx_d;
    logic             last_q, last_d;
    logic [AW-1:0]    next_q, next_d;
    logic [AW-1:0]    src_q, src_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             rd_req_q, rd_req_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic             cmd_valid_q, cmd_valid_d;

    logic start_ok_c;
    logic start_bad_c;
    logic word_c;
    logic desc_fin_c;
    logic chain_end_c;
    logic next_bad_c;

    // A zero-length descriptor completes in ISSUE without ever raising a command.
    assign start_ok_c  = (state_q == IDLE) && start_i && (start_addr_i[3:0] == 4'h0);
    assign start_bad_c = (state_q == IDLE) && start_i && (start_addr_i[3:0] != 4'h0);
    assign word_c      = (state_q == RD_DATA) && rd_valid_i;
    assign desc_fin_c  = ((state_q == WAIT_XFER) && xfer_done_i) ||
                         ((state_q == ISSUE) && (len_q == '0));
    assign chain_end_c = last_q || (next_q == '0);
    assign next_bad_c  = (next_q[3:0] != 4'h0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok_c) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (rd_gnt_i) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rd_valid_i) begin
                    if (idx_q == 2'd3) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            ISSUE, WAIT_XFER: begin
                if (desc_fin_c) begin
                    if (chain_end_c || next_bad_c) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RD_REQ;
                    end
                end else if ((state_q == ISSUE) && cmd_ready_i) begin
                    state_d = WAIT_XFER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and output next values, all aligned with state_d
    always_comb begin
        ptr_d  = ptr_q;
        idx_d  = idx_q;
        last_d = last_q;
        next_d = next_q;
        src_d  = src_q;
        dst_d  = dst_q;
        len_d  = len_q;
        err_d  = err_q;
        cnt_d  = cnt_q;

        if (start_ok_c) begin
            ptr_d = start_addr_i;
            idx_d = 2'd0;
            cnt_d = '0;
            err_d = 1'b0;
        end else if (start_bad_c) begin
            err_d = 1'b1;
        end

        if (word_c) begin
            case (idx_q)
                2'd0: src_d = rd_data_i;
                2'd1: dst_d = rd_data_i;
                2'd2: begin
                    len_d  = rd_data_i[LEN_W-1:0];
                    last_d = rd_data_i[31];
                end
                default: next_d = rd_data_i;
            endcase
            idx_d = idx_q + 2'd1;
        end

        if (desc_fin_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!chain_end_c) begin
                if (next_bad_c) begin
                    err_d = 1'b1;
                end else begin
                    ptr_d = next_q;
                    idx_d = 2'd0;
                end
            end
        end

        rd_req_d    = (state_d == RD_REQ);
        rd_addr_d   = ptr_d + AW'({idx_d, 2'b00});
        cmd_valid_d = (state_d == ISSUE) && (len_d != '0);
        done_d      = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            idx_q       <= 2'd0;
            last_q      <= 1'b0;
            next_q      <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            cmd_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            next_q      <= next_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign rd_req_o    = rd_req_q;
    assign rd_addr_o   = rd_addr_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_src_o   = src_q;
    assign cmd_dst_o   = dst_q;
    assign cmd_len_o   = len_q;
    assign desc_cnt_o  = cnt_q;

endmodule

// File: tb/tb_sgdmac_desc_ctrl.sv
// Bench for sgdmac_desc_ctrl: acts as descriptor memory and copy engine, and checks the DUT
// against a chain-walk model of the descriptor list computed up front for every job.
module tb_sgdmac_desc_ctrl;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
    } cmd_t;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [31:0] start_addr_i;
    logic        done_o;
    logic        busy_o;
    logic        err_o;
    logic        rd_req_o;
    logic [31:0] rd_addr_o;
    logic        rd_gnt_i;
    logic        rd_valid_i;
    logic [31:0] rd_data_i;
    logic        cmd_valid_o;
    logic        cmd_ready_i;
    logic [31:0] cmd_src_o;
    logic [31:0] cmd_dst_o;
    logic [15:0] cmd_len_o;
    logic        xfer_done_i;
    logic [15:0] desc_cnt_o;

    sgdmac_desc_ctrl #(.LEN_W(16), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .start_addr_i (start_addr_i),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .rd_req_o     (rd_req_o),
        .rd_addr_o    (rd_addr_o),
        .rd_gnt_i     (rd_gnt_i),
        .rd_valid_i   (rd_valid_i),
        .rd_data_i    (rd_data_i),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_ready_i  (cmd_ready_i),
        .cmd_src_o    (cmd_src_o),
        .cmd_dst_o    (cmd_dst_o),
        .cmd_len_o    (cmd_len_o),
        .xfer_done_i  (xfer_done_i),
        .desc_cnt_o   (desc_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_rd[$];
    cmd_t        exp_cmd[$];
    logic        model_err;
    logic [15:0] model_cnt;
    bit          exp_term_cmd;

    int   gnt_mode;
    int   fixed_stall;
    bit   stray_en;
    int   first_rdreq_cyc;
    int   first_cmdv_cyc;
    int   last_xfer_cyc;
    int   n_cmd_obs;
    int   gnt_cyc[$];
    cmd_t obs_cmd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0BAD_F00D;
    endfunction

    task automatic put_desc(input logic [31:0] a, input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] ctrl, input logic [31:0] nxt);
        mem[a]         = s;
        mem[a + 32'd4] = d;
        mem[a + 32'd8] = ctrl;
        mem[a + 32'd12] = nxt;
    endtask

    function automatic int pick_stall();
        if (fixed_stall >= 0) return fixed_stall;
        return int'($urandom_range(0, 3));
    endfunction

    // Walk the descriptor list in memory and list every read and command the DUT must produce.
    task automatic model_build(input logic [31:0] start);
        logic [31:0] p, s, d, ctrl, nxt;
        exp_rd.delete();
        exp_cmd.delete();
        exp_term_cmd = 0;
        if (start[3:0] != 4'h0) begin
            model_err = 1'b1;
            return;
        end
        model_err = 1'b0;
        model_cnt = 16'd0;
        p = start;
        for (int dn = 0; dn < 16; dn++) begin
            for (int w = 0; w < 4; w++) exp_rd.push_back(p + 32'(4 * w));
            s    = mem_rd(p);
            d    = mem_rd(p + 32'd4);
            ctrl = mem_rd(p + 32'd8);
            nxt  = mem_rd(p + 32'd12);
            model_cnt = model_cnt + 16'd1;
            if (ctrl[15:0] != 16'd0) exp_cmd.push_back({s, d, ctrl[15:0]});
            exp_term_cmd = (ctrl[15:0] != 16'd0);
            if (ctrl[31] || nxt == 32'd0) break;
            if (nxt[3:0] != 4'h0) begin
                model_err = 1'b1;
                break;
            end
            p = nxt;
        end
    endtask

    task automatic check_reset();
        chk("rst_done", done_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rd_req", rd_req_o, 0);
        chk("rst_rd_addr", rd_addr_o, 0);
        chk("rst_cmd_valid", cmd_valid_o, 0);
        chk("rst_cmd_src", cmd_src_o, 0);
        chk("rst_cmd_dst", cmd_dst_o, 0);
        chk("rst_cmd_len", cmd_len_o, 0);
        chk("rst_desc_cnt", desc_cnt_o, 0);
    endtask

    task automatic do_abort();
        start_addr_i = 32'h100;
        start_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_start_ignored", {rd_req_o, done_o, cmd_valid_o}, 3'b000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset();
        xfer_done_i = 1'b1;
        rd_valid_i  = 1'b1;
        rd_data_i   = $urandom();
        @(negedge clk);
        xfer_done_i = 1'b0;
        rd_valid_i  = 1'b0;
        chk("stray_after_reset", {done_o, busy_o, rd_req_o, cmd_valid_o, err_o}, 5'b10000);
        chk("cnt_after_reset", desc_cnt_o, 0);
        model_err = 1'b0;
        model_cnt = 16'd0;
    endtask

    // Runs one job starting at the current negedge with the DUT idle; acts as memory and engine.
    task automatic run_job(input logic [31:0] start, input bit abort);
        bit          rd_pend   = 0;
        int          rd_dly    = 0;
        logic [31:0] rd_a      = '0;
        bit          xfer_pend = 0;
        int          xfer_dly  = 0;
        int          stall_cnt = 0;
        int          stall_target;
        bit          cmd_wait  = 0;
        bit          abort_now = 0;
        bit          finished  = 0;
        int          cyc       = 0;

        stall_target = pick_stall();
        model_build(start);
        gnt_cyc.delete();
        first_rdreq_cyc = -1;
        first_cmdv_cyc  = -1;
        last_xfer_cyc   = -100;
        n_cmd_obs       = 0;

        start_addr_i = start;
        start_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;

        if (start[3:0] != 4'h0) begin
            for (int i = 0; i < 4; i++) begin
                chk("bad_start_idle", {rd_req_o, done_o}, 2'b01);
                @(negedge clk);
            end
            chk("bad_start_err", err_o, model_err);
            chk("bad_start_cnt", desc_cnt_o, model_cnt);
            return;
        end
        chk("start_latency", {rd_req_o, done_o, busy_o}, 3'b101);

        while (!finished && cyc < 3000) begin
            rd_gnt_i    = 1'b0;
            rd_valid_i  = 1'b0;
            cmd_ready_i = 1'b0;
            xfer_done_i = 1'b0;
            start_i     = 1'b0;
            rd_data_i   = $urandom();
            chk("busy_vs_done", busy_o, !done_o);

            if (done_o) begin
                finished = 1;
            end else if (abort_now) begin
                do_abort();
                return;
            end else begin
                if (rd_pend) begin
                    if (rd_dly == 0) begin
                        rd_valid_i = 1'b1;
                        rd_data_i  = mem_rd(rd_a);
                        rd_pend    = 0;
                    end else begin
                        rd_dly--;
                    end
                end else if (stray_en && $urandom_range(0, 7) == 0) begin
                    rd_valid_i = 1'b1;
                end

                if (rd_req_o) begin
                    if (first_rdreq_cyc < 0) first_rdreq_cyc = cyc;
                    chk("read_expected", exp_rd.size() != 0, 1);
                    if (exp_rd.size() != 0) chk("rd_addr", rd_addr_o, exp_rd[0]);
                    if (gnt_mode == 1 || $urandom_range(0, 2) == 0) begin
                        rd_gnt_i = 1'b1;
                        rd_pend  = 1;
                        rd_a     = rd_addr_o;
                        rd_dly   = (gnt_mode == 1) ? 0 : int'($urandom_range(0, 2));
                        gnt_cyc.push_back(cyc);
                        if (exp_rd.size() != 0) void'(exp_rd.pop_front());
                    end
                end

                if (xfer_pend) begin
                    if (xfer_dly == 0) begin
                        xfer_done_i   = 1'b1;
                        xfer_pend     = 0;
                        last_xfer_cyc = cyc;
                    end else begin
                        xfer_dly--;
                    end
                end else if (stray_en && $urandom_range(0, 7) == 0) begin
                    xfer_done_i = 1'b1;
                end

                if (cmd_valid_o) begin
                    if (first_cmdv_cyc < 0) first_cmdv_cyc = cyc;
                    chk("cmd_expected", exp_cmd.size() != 0, 1);
                    if (exp_cmd.size() != 0) begin
                        chk("cmd_src", cmd_src_o, exp_cmd[0].src);
                        chk("cmd_dst", cmd_dst_o, exp_cmd[0].dst);
                        chk("cmd_len", cmd_len_o, exp_cmd[0].len);
                    end
                    if (stall_cnt >= stall_target) begin
                        cmd_ready_i = 1'b1;
                        xfer_pend   = 1;
                        xfer_dly    = (gnt_mode == 1) ? 0 : int'($urandom_range(0, 3));
                        obs_cmd     = {cmd_src_o, cmd_dst_o, cmd_len_o};
                        n_cmd_obs++;
                        if (exp_cmd.size() != 0) void'(exp_cmd.pop_front());
                        stall_cnt    = 0;
                        stall_target = pick_stall();
                        cmd_wait     = 0;
                        if (abort) abort_now = 1;
                    end else begin
                        stall_cnt++;
                        cmd_wait = 1;
                    end
                end else begin
                    if (cmd_wait) chk("cmd_valid_held", cmd_valid_o, 1);
                    cmd_wait = 0;
                end

                if (stray_en && $urandom_range(0, 15) == 0) begin
                    start_i      = 1'b1;
                    start_addr_i = $urandom() & 32'hFFFF_FFF0;
                end
            end

            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end

        chk("job_finished", finished, 1);
        if (!finished) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            model_err = 1'b0;
            model_cnt = 16'd0;
            return;
        end
        chk("reads_left", exp_rd.size(), 0);
        chk("cmds_left", exp_cmd.size(), 0);
        chk("err_final", err_o, model_err);
        chk("cnt_final", desc_cnt_o, model_cnt);
        if (exp_term_cmd) chk("done_latency", cyc, last_xfer_cyc + 1);
    endtask

    task automatic gen_chain(output logic [31:0] start);
        int          n;
        logic [31:0] base, a, nxt, ctrl;
        logic [15:0] len;
        n    = int'($urandom_range(1, 4));
        base = $urandom() & 32'hFFFF_0000;
        mem.delete();
        for (int k = 0; k < n; k++) begin
            a    = base + 32'(k * 64);
            len  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            ctrl = {1'b0, 15'($urandom()), len};
            if (k == n - 1) begin
                if ($urandom_range(0, 1) == 0) begin
                    ctrl[31] = 1'b1;
                    nxt      = $urandom();
                end else begin
                    nxt = 32'd0;
                end
            end else begin
                nxt = base + 32'((k + 1) * 64);
                if ($urandom_range(0, 7) == 0) nxt[3:0] = 4'($urandom_range(1, 15));
            end
            put_desc(a, $urandom(), $urandom(), ctrl, nxt);
        end
        start = base;
        if ($urandom_range(0, 9) == 0) start[3:0] = 4'($urandom_range(1, 15));
    endtask

    initial begin
        logic [31:0] st;
        rst          = 1'b1;
        start_i      = 1'b0;
        start_addr_i = '0;
        rd_gnt_i     = 1'b0;
        rd_valid_i   = 1'b0;
        rd_data_i    = '0;
        cmd_ready_i  = 1'b0;
        xfer_done_i  = 1'b0;
        gnt_mode     = 0;
        fixed_stall  = -1;
        stray_en     = 0;
        model_err    = 1'b0;
        model_cnt    = 16'd0;
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b0;
        @(negedge clk);

        // Single descriptor, grant tied high and data one cycle after grant
        gnt_mode    = 1;
        fixed_stall = 0;
        mem.delete();
        put_desc(32'h100, 32'h1000, 32'h2000, 32'h8000_0040, 32'h0);
        run_job(32'h100, 0);
        chk("single_src", obs_cmd.src, 32'h1000);
        chk("single_dst", obs_cmd.dst, 32'h2000);
        chk("single_len", obs_cmd.len, 16'h40);
        chk("single_ncmd", n_cmd_obs, 1);
        chk("single_cnt", desc_cnt_o, 1);
        chk("single_done", done_o, 1);
        chk("fetch_cycles", first_cmdv_cyc - first_rdreq_cyc, 8);

        // Three-descriptor chain with command ready stalled 5 cycles each
        fixed_stall = 5;
        mem.delete();
        put_desc(32'h100, 32'h1100, 32'h2100, 32'h0000_0010, 32'h200);
        put_desc(32'h200, 32'h1200, 32'h2200, 32'h0000_0020, 32'h300);
        put_desc(32'h300, 32'h1300, 32'h2300, 32'h8000_0030, 32'h0);
        run_job(32'h100, 0);
        chk("chain_ncmd", n_cmd_obs, 3);
        chk("chain_last_src", obs_cmd.src, 32'h1300);
        chk("chain_cnt", desc_cnt_o, 3);

        // Misaligned start flags an error, next good start clears it
        fixed_stall = 0;
        run_job(32'h104, 0);
        chk("misalign_err", err_o, 1);
        chk("misalign_done", done_o, 1);
        run_job(32'h100, 0);
        chk("restart_err_clear", err_o, 0);
        chk("restart_cnt", desc_cnt_o, 3);

        // Middle descriptor with zero length
        mem.delete();
        put_desc(32'h100, 32'h1100, 32'h2100, 32'h0000_0010, 32'h200);
        put_desc(32'h200, 32'h1200, 32'h2200, 32'h0000_0000, 32'h300);
        put_desc(32'h300, 32'h1300, 32'h2300, 32'h8000_0030, 32'h0);
        run_job(32'h100, 0);
        chk("zlen_ncmd", n_cmd_obs, 2);
        chk("zlen_cnt", desc_cnt_o, 3);
        chk("zlen_grants", gnt_cyc.size(), 12);
        if (gnt_cyc.size() == 12) chk("zlen_refetch_gap", gnt_cyc[8] - gnt_cyc[4], 9);

        // Misaligned NEXT on a non-last descriptor
        mem.delete();
        put_desc(32'h100, 32'h1000, 32'h2000, 32'h0000_0040, 32'h208);
        put_desc(32'h200, 32'h1200, 32'h2200, 32'h8000_0020, 32'h0);
        run_job(32'h100, 0);
        chk("badnext_err", err_o, 1);
        chk("badnext_cnt", desc_cnt_o, 1);
        chk("badnext_grants", gnt_cyc.size(), 4);

        // Reset while waiting for the transfer, with stray pulses around it
        fixed_stall = 2;
        mem.delete();
        put_desc(32'h100, 32'h1000, 32'h2000, 32'h8000_0040, 32'h0);
        run_job(32'h100, 1);

        // Randomized chains, handshakes and stray pulses
        gnt_mode    = 0;
        fixed_stall = -1;
        stray_en    = 1;
        for (int j = 0; j < 40; j++) begin
            gen_chain(st);
            run_job(st, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sgdmac_desc_ctrl.md
SGDMAC_DESC_CTRL -- requirements
Module: SGDMAC_DESC_CTRL

Interface
REQ-001 SHALL have parameter LEN_W, default 16, transfer byte-length width.
REQ-002 SHALL have parameter CNT_W, default 16, completed-descriptor counter width.
REQ-003 SHALL have clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have start_i  in  1  one-cycle start pulse from the APB configuration block; start_addr_i  in  32  first descriptor address.
REQ-006 SHALL have done_o  out  1  high when idle, to the configuration block's done input; busy_o  out  1  equals ~done_o; err_o  out  1  sticky misaligned-pointer flag.
REQ-007 SHALL have rd_req_o  out  1; rd_addr_o  out  32; rd_gnt_i  in  1  read accepted; rd_valid_i  in  1; rd_data_i  in  32  descriptor-read port.
REQ-008 SHALL have cmd_valid_o  out  1; cmd_ready_i  in  1; cmd_src_o  out  32; cmd_dst_o  out  32; cmd_len_o  out  LEN_W  transfer command to the copy engine.
REQ-009 SHALL have xfer_done_i  in  1  one-cycle pulse when the engine finishes the issued command; desc_cnt_o  out  CNT_W  descriptors completed since last start.

Function
REQ-010 SHALL interpret a descriptor as 4 words at ptr+0/4/8/12: SRC, DST, CTRL {bit31 LAST, bits[LEN_W-1:0] LEN}, NEXT.
REQ-011 SHALL implement states IDLE, RD_REQ, RD_DATA, ISSUE, WAIT_XFER.
REQ-012 IDLE: done_o=1; on start_i with start_addr_i[3:0]==0, SHALL load ptr=start_addr_i, word index=0, desc_cnt_o=0, clear err_o, go RD_REQ.
REQ-013 IDLE: on start_i with start_addr_i[3:0]!=0, SHALL set err_o=1 and remain in IDLE.
REQ-014 RD_REQ: rd_req_o=1, rd_addr_o=ptr+4*index, both held stable until rd_gnt_i; on rd_gnt_i go RD_DATA.
REQ-015 RD_DATA: rd_req_o=0; on rd_valid_i latch rd_data_i into word[index]; index<3 -> index+1, RD_REQ; index==3 -> ISSUE.
REQ-016 SHALL keep at most one read outstanding; rd_valid_i outside RD_DATA SHALL be ignored.
REQ-017 ISSUE: if LEN==0, SHALL not assert cmd_valid_o and SHALL proceed as if xfer_done_i arrived (REQ-019) in the same cycle.
REQ-018 ISSUE, LEN!=0: cmd_valid_o=1 with SRC/DST/LEN stable until cmd_ready_i; on cmd_ready_i go WAIT_XFER.
REQ-019 WAIT_XFER: on xfer_done_i increment desc_cnt_o (wrap modulo 2^CNT_W); if LAST==1 or NEXT==0 -> IDLE; else if NEXT[3:0]!=0 -> set err_o, IDLE; else ptr=NEXT, index=0, RD_REQ.
REQ-020 xfer_done_i outside WAIT_XFER SHALL be ignored; start_i outside IDLE SHALL be ignored.
REQ-021 Latency: start_i in cycle N -> rd_req_o=1 and done_o=0 in cycle N+1; return to IDLE -> done_o=1 the cycle after the terminating xfer_done_i.
REQ-022 With rd_gnt_i tied 1 and rd_valid_i one cycle after grant, a fetch SHALL take 8 cycles from first rd_req_o to ISSUE.
REQ-023 Address arithmetic SHALL be 32-bit, wrapping at 2^32.
REQ-024 cmd_src_o/cmd_dst_o/cmd_len_o SHALL be registered; values outside ISSUE are don't-care.

Reset
REQ-025 rst=1 SHALL force IDLE in the next cycle from any state, abandoning any outstanding read or command.
REQ-026 Reset values: done_o=1, busy_o=0, err_o=0, rd_req_o=0, rd_addr_o=0, cmd_valid_o=0, cmd_src_o=0, cmd_dst_o=0, cmd_len_o=0, desc_cnt_o=0.
REQ-027 After reset, rd_valid_i or xfer_done_i responses to abandoned operations SHALL be ignored.

Verification
REQ-028 Single descriptor at 0x100 {0x1000,0x2000,0x8000_0040,0}: start -> one command src=0x1000 dst=0x2000 len=0x40; done_o=1 after xfer_done_i; desc_cnt_o=1.
REQ-029 Chain 0x100->0x200->0x300 (LAST at 0x300), cmd_ready_i stalled 5 cycles each -> three commands in order, cmd fields stable during stall, desc_cnt_o=3.
REQ-030 start_addr_i=0x104 -> err_o=1, no rd_req_o, done_o stays 1; next start at 0x100 clears err_o.
REQ-031 Middle descriptor LEN=0 -> no cmd_valid_o for it, fetch of next begins next cycle, desc_cnt_o counts it.
REQ-032 NEXT=0x208 (misaligned) on non-last descriptor -> err_o=1, done_o=1 after that xfer_done_i, no further reads.
REQ-033 rst asserted in WAIT_XFER, late xfer_done_i and start_i pulsed during busy -> IDLE with reset values; stray pulses cause no state change.
